digit_scan_ctrl: RTL and testbench

//  Scan controller for a 4-digit multiplexed 7-segment display. Sits directly

---
 rtl/digit_scan_ctrl_if.sv | 32 +++
 rtl/digit_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_digit_scan_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/digit_scan_ctrl_if.sv
// Bus interface for digit_scan_ctrl.
//   master : the value/control source (drives en, load, value; observes display side)
//   slave  : the scan controller itself
// Signals:
//   en         scan enable
//   load       one-cycle strobe capturing value into the shadow register
//   value      four BCD digits, [15:12] most significant
//   sel_a      digit index bit 1 (decoder input a)
//   sel_b      digit index bit 0 (decoder input b)
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   pending    shadow holds an uncommitted value
//   frame_done one-cycle pulse on each commit
interface digit_scan_ctrl_if;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic        sel_a;
  logic        sel_b;
  logic [6:0]  seg;
  logic        pending;
  logic        frame_done;

  modport master (
    output en, load, value,
    input  sel_a, sel_b, seg, pending, frame_done
  );

  modport slave (
    input  en, load, value,
    output sel_a, sel_b, seg, pending, frame_done
  );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed 7-segment display.
// Drives the 2-to-4 digit decoder select lines and the matching active-low
// segment pattern. A new 4-digit BCD value is held in a shadow register and
// committed to the display register only when the digit index wraps 3->0,
// so a digit never tears mid-frame.
//
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  synchronous reset, active-high
//   bus  slave modport of digit_scan_ctrl_if (en, load, value in;
//        sel_a, sel_b, seg, pending, frame_done out)
// Parameters:
//   DIV_WIDTH  prescaler counter width
//   DIV_MAX    prescaler terminal count (one tick every DIV_MAX+1 enabled cycles)
// Configuration:
//   LEADING_ZERO_BLANK_EN  when defined, digits 3..1 are blanked while they
//                          and every more significant digit are zero.
module digit_scan_ctrl #(
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned DIV_MAX   = 49999
) (
  input logic               clk,
  input logic               rst,
  digit_scan_ctrl_if.slave  bus
);

  localparam logic [DIV_WIDTH-1:0] DIV_MAX_C = DIV_WIDTH'(DIV_MAX);
  localparam logic [6:0]           SEG_BLANK = 7'h7F;

  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]           idx_q, idx_d;
  logic [15:0]          shadow_q, shadow_d;
  logic [15:0]          disp_q, disp_d;
  logic                 pending_q, pending_d;
  logic                 frame_done_q, frame_done_d;

  logic                 tick;
  logic                 commit;
  logic [3:0]           nibble;
  logic [6:0]           seg_c;
  logic                 blank_lz;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    tick   = bus.en && (div_cnt_q == DIV_MAX_C);
    commit = tick && (idx_q == 2'd3);

    div_cnt_d = div_cnt_q;
    idx_d     = idx_q;
    if (bus.en) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      if (tick) idx_d = idx_q + 2'd1;
    end

    shadow_d = bus.load ? bus.value : shadow_q;

    // A load landing on the commit tick bypasses the shadow straight to disp,
    // so pending never stays set for a value that is already on display.
    disp_d    = disp_q;
    pending_d = pending_q;
    if (commit) begin
      disp_d    = bus.load ? bus.value : shadow_q;
      pending_d = 1'b0;
    end else if (bus.load) begin
      pending_d = 1'b1;
    end

    frame_done_d = commit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    nibble = disp_q[{idx_q, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    // Digit k is a leading zero when nibbles k..3 are all zero; digit 0 always shows.
    case (idx_q)
      2'd3:    blank_lz = (disp_q[15:12] == 4'd0);
      2'd2:    blank_lz = (disp_q[15:8]  == 8'd0);
      2'd1:    blank_lz = (disp_q[15:4]  == 12'd0);
      default: blank_lz = 1'b0;
    endcase
`else
    blank_lz = 1'b0;
`endif
    seg_c = blank_lz ? SEG_BLANK : bcd_to_seg(nibble);
  end

  assign bus.sel_a      = idx_q[1];
  assign bus.sel_b      = idx_q[0];
  assign bus.seg        = seg_c;
  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
module tb_digit_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  digit_scan_ctrl_if bus_if ();

  digit_scan_ctrl #(
    .DIV_WIDTH (16),
    .DIV_MAX   (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  // One counter of enabled cycles modulo 16 covers both prescaler (4) and
  // digit index (4); the commit point is the last enabled cycle of the frame.
  int unsigned m_ecount;
  logic [15:0] m_shadow, m_disp;
  logic        m_pending, m_fd;
  bit          chk_en = 1'b0;

  logic [6:0] seg_tab [16];
  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  end

  function automatic int unsigned m_idx();
    return m_ecount / 4;
  endfunction

  function automatic logic [6:0] m_seg();
    int unsigned k;
    logic [3:0]  d [4];
    bit          all_zero;
    k = m_idx();
    for (int unsigned i = 0; i < 4; i++) d[i] = 4'((m_disp >> (4 * i)) & 16'hF);
    all_zero = 1'b1;
    for (int unsigned i = k; i < 4; i++) if (d[i] != 4'd0) all_zero = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (k != 0 && all_zero) return 7'h7F;
`endif
    return seg_tab[d[k]];
  endfunction

  always @(posedge clk) begin
    bit commit;
    if (rst) begin
      m_ecount  = 0;
      m_shadow  = '0;
      m_disp    = '0;
      m_pending = 1'b0;
      m_fd      = 1'b0;
    end else begin
      commit = bus_if.en && (m_ecount == 15);
      m_fd   = commit;
      if (commit) begin
        m_disp    = bus_if.load ? bus_if.value : m_shadow;
        m_pending = 1'b0;
      end else if (bus_if.load) begin
        m_pending = 1'b1;
      end
      if (bus_if.load) m_shadow = bus_if.value;
      if (bus_if.en) m_ecount = (m_ecount + 1) % 16;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if ({bus_if.sel_a, bus_if.sel_b} != 2'(m_idx())) begin
        n_fail++;
        $display("FAIL sel t=%0t got=%0d exp=%0d", $time, {bus_if.sel_a, bus_if.sel_b}, m_idx());
      end
      n_checks++;
      if (bus_if.seg !== m_seg()) begin
        n_fail++;
        $display("FAIL seg t=%0t got=%h exp=%h", $time, bus_if.seg, m_seg());
      end
      n_checks++;
      if (bus_if.pending !== m_pending) begin
        n_fail++;
        $display("FAIL pending t=%0t got=%b exp=%b", $time, bus_if.pending, m_pending);
      end
      n_checks++;
      if (bus_if.frame_done !== m_fd) begin
        n_fail++;
        $display("FAIL frame_done t=%0t got=%b exp=%b", $time, bus_if.frame_done, m_fd);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic wait_sel(input int s, input string name);
    int n = 0;
    while ({bus_if.sel_a, bus_if.sel_b} != 2'(s) && n < 64) begin
      cyc();
      n++;
    end
    check({name, "_wait_sel"}, int'(n < 64), 1);
  endtask

  task automatic wait_fd(input string name);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!bus_if.frame_done && n < 64);
    check({name, "_wait_fd"}, int'(bus_if.frame_done), 1);
  endtask

  task automatic load_val(input logic [15:0] v);
    bus_if.load  = 1'b1;
    bus_if.value = v;
    cyc();
    bus_if.load  = 1'b0;
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'h7F;
`else
  localparam logic [6:0] LZ_SEG = 7'h40;
`endif

  // ---------------- stimulus ----------------
  initial begin
    int fd_cnt;
    int held_sel;
    rst          = 1'b1;
    bus_if.en    = 1'b0;
    bus_if.load  = 1'b1;       // load during reset is discarded
    bus_if.value = 16'h9999;
    cyc(); cyc();
    rst          = 1'b0;
    bus_if.load  = 1'b0;
    cyc();
    chk_en = 1'b1;

    // Reset state
    check("rst_sel", {bus_if.sel_a, bus_if.sel_b}, 0);
    check("rst_seg", bus_if.seg, 7'h40);
    check("rst_pending", bus_if.pending, 0);
    check("rst_fd", bus_if.frame_done, 0);

    // Scan: 32 enabled cycles contain exactly two commits
    bus_if.en = 1'b1;
    fd_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cyc();
      if (bus_if.frame_done) fd_cnt++;
    end
    check("scan_fd_count", fd_cnt, 2);

    // Commit of 1234 loaded while idx=1
    wait_sel(1, "commit");
    load_val(16'h1234);
    check("commit_pending", bus_if.pending, 1);
    check("commit_seg_old", bus_if.seg, 7'h40);
    wait_fd("commit");
    check("commit_idx0", bus_if.seg, 7'h19);
    wait_sel(3, "commit3");
    check("commit_idx3", bus_if.seg, 7'h79);
    check("commit_pending_clr", bus_if.pending, 0);

    // Invalid BCD nibbles blank
    load_val(16'h00AF);
    wait_fd("inval");
    check("inval_idx0", bus_if.seg, 7'h7F);
    wait_sel(1, "inval1");
    check("inval_idx1", bus_if.seg, 7'h7F);
    wait_sel(2, "inval2");
    check("inval_idx2", bus_if.seg, LZ_SEG);

    // Freeze with a load in the middle
    bus_if.en = 1'b0;
    cyc();
    held_sel = {bus_if.sel_a, bus_if.sel_b};
    for (int i = 0; i < 20; i++) begin
      if (i == 7) load_val(16'h5678);
      else cyc();
    end
    check("freeze_sel", {bus_if.sel_a, bus_if.sel_b}, held_sel);
    check("freeze_pending", bus_if.pending, 1);

    // Load coinciding with the commit tick
    bus_if.en = 1'b1;
    begin
      int n = 0;
      while (m_ecount != 15 && n < 64) begin
        cyc();
        n++;
      end
      check("coll_reach", int'(m_ecount == 15), 1);
    end
    load_val(16'h9876);
    check("coll_fd", bus_if.frame_done, 1);
    check("coll_pending", bus_if.pending, 0);
    check("coll_idx0", bus_if.seg, 7'h02);

    // Leading-zero value
    load_val(16'h0050);
    wait_fd("lz");
    check("lz_d0", bus_if.seg, 7'h40);
    wait_sel(1, "lz1");
    check("lz_d1", bus_if.seg, 7'h12);
    wait_sel(2, "lz2");
    check("lz_d2", bus_if.seg, LZ_SEG);
    wait_sel(3, "lz3");
    check("lz_d3", bus_if.seg, LZ_SEG);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bus_if.en   = ($urandom_range(3) != 0);
      bus_if.load = ($urandom_range(7) == 0);
      case ($urandom_range(3))
        0:       bus_if.value = 16'($urandom_range(255));
        1:       bus_if.value = 16'($urandom);
        default: bus_if.value = {4'($urandom_range(9)), 4'($urandom_range(9)),
                                 4'($urandom_range(9)), 4'($urandom_range(9))};
      endcase
      rst = ($urandom_range(199) == 0);
      cyc();
    end
    rst         = 1'b0;
    bus_if.load = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
